// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared constants and types for the fetch front end:
//               datapath width, canonical NOP encoding and register-field
//               bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_MSB = 24;
  localparam int unsigned RS2_LSB = 20;

  typedef logic [4:0] reg_addr_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/if_id_stage_if.sv
`default_nettype none
// ============================================================================
// Interface   : if_id_stage_if
// Description : Hazard controls, instruction-memory bus and IF/ID outputs of
//               the fetch front end. The slave modport is the stage itself;
//               the master modport is its environment (hazard unit, imem, ID).
// Revision    : 1.0 - initial release
// ============================================================================
interface if_id_stage_if #(
  parameter int unsigned XLEN = cpu_pkg::XLEN
);

  logic                PCWrite_i;
  logic                Stall_i;
  logic                Flush_i;
  logic [XLEN-1:0]     BranchTarget_i;
  logic [XLEN-1:0]     instr_addr_o;
  logic [31:0]         instr_i;
  logic [XLEN-1:0]     IFID_pc_o;
  logic [31:0]         IFID_instr_o;
  logic                IFID_valid_o;
  cpu_pkg::reg_addr_t  RS1addr_o;
  cpu_pkg::reg_addr_t  RS2addr_o;
  logic [31:0]         stall_cnt_o;
  logic [31:0]         flush_cnt_o;

  modport master (
    output PCWrite_i, Stall_i, Flush_i, BranchTarget_i, instr_i,
    input  instr_addr_o, IFID_pc_o, IFID_instr_o, IFID_valid_o,
           RS1addr_o, RS2addr_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  PCWrite_i, Stall_i, Flush_i, BranchTarget_i, instr_i,
    output instr_addr_o, IFID_pc_o, IFID_instr_o, IFID_valid_o,
           RS1addr_o, RS2addr_o, stall_cnt_o, flush_cnt_o
  );

endinterface : if_id_stage_if
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter with hold / redirect / sequential-increment
//               selection. Hold wins over redirect so a stalled branch cannot
//               move the PC.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pc_write_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // next PC: hold, branch redirect, or sequential step (wraps naturally)
  always_comb begin
    pc_d = pc_q;
    if (pc_write_i) begin
      if (flush_i) begin
        pc_d = target_i;
      end else begin
        pc_d = pc_q + XLEN'(PC_STEP);
      end
    end
  end

  // PC register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : pc_reg
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : Fetch front end - PC register plus IF/ID pipeline register.
//               Stall holds IF/ID (and masks a flush), flush inserts a NOP
//               bubble, otherwise the fetched instruction is captured.
//               Optional macro IFID_PERF_EN adds saturating stall/flush
//               counters; without it the counter outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage #(
  parameter int unsigned     XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  if_id_stage_if.slave  bus
);

  import cpu_pkg::*;

  logic [XLEN-1:0] pc;

  logic [XLEN-1:0] ifid_pc_d,    ifid_pc_q;
  logic [31:0]     ifid_instr_d, ifid_instr_q;
  logic            ifid_valid_d, ifid_valid_q;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .pc_write_i (bus.PCWrite_i),
    .flush_i    (bus.Flush_i),
    .target_i   (bus.BranchTarget_i),
    .pc_o       (pc)
  );

  // next IF/ID contents: stall holds, flush squashes, otherwise capture fetch
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (!bus.Stall_i) begin
      if (bus.Flush_i) begin
        ifid_pc_d    = '0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end else begin
        ifid_pc_d    = pc;
        ifid_instr_d = bus.instr_i;
        ifid_valid_d = 1'b1;
      end
    end
  end

  // IF/ID pipeline register, resets to a NOP bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign bus.instr_addr_o = pc;
  assign bus.IFID_pc_o    = ifid_pc_q;
  assign bus.IFID_instr_o = ifid_instr_q;
  assign bus.IFID_valid_o = ifid_valid_q;
  assign bus.RS1addr_o    = ifid_instr_q[RS1_MSB:RS1_LSB];
  assign bus.RS2addr_o    = ifid_instr_q[RS2_MSB:RS2_LSB];

`ifdef IFID_PERF_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  // saturating event counters; a flush only counts when not masked by stall
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.Stall_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (bus.Flush_i && !bus.Stall_i && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`else
  assign bus.stall_cnt_o = '0;
  assign bus.flush_cnt_o = '0;
`endif

endmodule : if_id_stage
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_stage
// Description : Scoreboard bench for if_id_stage. Directed vectors push the
//               hand-computed post-edge state into a queue; a monitor pops and
//               compares on each falling edge (or on demand for the
//               asynchronous-reset check). The imem returns
//               {addr[15:0], 16'h0033} so RS fields track the fetch address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;
`ifdef IFID_PERF_EN
  localparam logic [31:0] PERF_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] PERF_MASK = 32'h0000_0000;
`endif

  typedef struct {
    int          cyc;
    string       nm;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_id_stage_if bus ();

  if_id_stage dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  assign bus.instr_i = {bus.instr_addr_o[15:0], 16'h0033};

  exp_t q[$];
  int   n_vec   = 0;
  int   n_miss  = 0;
  int   cyc_cnt = 0;
  event chk_now;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic expect_at(input int tag, input string nm,
                           input logic [31:0] a, input logic [31:0] p,
                           input logic [31:0] i, input logic v,
                           input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] sc, input logic [31:0] fc);
    exp_t e;
    e.cyc = tag;  e.nm = nm;  e.addr = a;  e.pc = p;  e.instr = i;
    e.valid = v;  e.rs1 = r1; e.rs2 = r2;
    e.sc = sc & PERF_MASK;
    e.fc = fc & PERF_MASK;
    q.push_back(e);
  endtask

  // drive controls for one edge and queue the state expected after it
  task automatic vec(input string nm, input logic pcw, input logic st,
                     input logic fl, input logic [31:0] tgt,
                     input logic [31:0] a, input logic [31:0] p,
                     input logic [31:0] i, input logic v,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic [31:0] sc, input logic [31:0] fc);
    bus.PCWrite_i      = pcw;
    bus.Stall_i        = st;
    bus.Flush_i        = fl;
    bus.BranchTarget_i = tgt;
    expect_at(cyc_cnt + 1, nm, a, p, i, v, r1, r2, sc, fc);
    @(posedge clk);
    #1;
  endtask

  // monitor: compare every expectation whose cycle has been reached
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        e = q.pop_front();
        n_vec++;
        if (bus.instr_addr_o !== e.addr || bus.IFID_pc_o !== e.pc ||
            bus.IFID_instr_o !== e.instr || bus.IFID_valid_o !== e.valid ||
            bus.RS1addr_o !== e.rs1 || bus.RS2addr_o !== e.rs2 ||
            bus.stall_cnt_o !== e.sc || bus.flush_cnt_o !== e.fc) begin
          n_miss++;
          $display("FAIL %s: got addr=%h pc=%h instr=%h v=%b rs1=%0d rs2=%0d sc=%h fc=%h | want addr=%h pc=%h instr=%h v=%b rs1=%0d rs2=%0d sc=%h fc=%h",
                   e.nm, bus.instr_addr_o, bus.IFID_pc_o, bus.IFID_instr_o,
                   bus.IFID_valid_o, bus.RS1addr_o, bus.RS2addr_o,
                   bus.stall_cnt_o, bus.flush_cnt_o,
                   e.addr, e.pc, e.instr, e.valid, e.rs1, e.rs2, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int tries;
    logic [31:0] a;
    bus.PCWrite_i      = 1'b1;
    bus.Stall_i        = 1'b0;
    bus.Flush_i        = 1'b0;
    bus.BranchTarget_i = 32'h0;

    #1;
    expect_at(cyc_cnt, "reset", 32'h0, 32'h0, TB_NOP, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;

    //   name            pcw   stall flush target          addr            ifid_pc         ifid_instr      v     rs1    rs2    stall  flush
    vec("free1",         1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_0004,  32'h0000_0000,  32'h0000_0033,  1'b1, 5'd0,  5'd0,  32'd0, 32'd0);
    vec("free2",         1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_0008,  32'h0000_0004,  32'h0004_0033,  1'b1, 5'd8,  5'd0,  32'd0, 32'd0);
    vec("ldu_hold",      1'b0, 1'b1, 1'b0, 32'h0,          32'h0000_0008,  32'h0000_0004,  32'h0004_0033,  1'b1, 5'd8,  5'd0,  32'd1, 32'd0);
    vec("resume",        1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_000C,  32'h0000_0008,  32'h0008_0033,  1'b1, 5'd16, 5'd0,  32'd1, 32'd0);
    vec("free3",         1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_0010,  32'h0000_000C,  32'h000C_0033,  1'b1, 5'd24, 5'd0,  32'd1, 32'd0);
    vec("flush",         1'b1, 1'b0, 1'b1, 32'h0000_0040,  32'h0000_0040,  32'h0000_0000,  TB_NOP,         1'b0, 5'd0,  5'd0,  32'd1, 32'd1);
    vec("tgt_fetch",     1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_0044,  32'h0000_0040,  32'h0040_0033,  1'b1, 5'd0,  5'd4,  32'd1, 32'd1);
    vec("flush_stalled", 1'b0, 1'b1, 1'b1, 32'h0000_0080,  32'h0000_0044,  32'h0000_0040,  32'h0040_0033,  1'b1, 5'd0,  5'd4,  32'd2, 32'd1);
    vec("stall3",        1'b0, 1'b1, 1'b0, 32'h0,          32'h0000_0044,  32'h0000_0040,  32'h0040_0033,  1'b1, 5'd0,  5'd4,  32'd3, 32'd1);
    vec("stall4",        1'b0, 1'b1, 1'b0, 32'h0,          32'h0000_0044,  32'h0000_0040,  32'h0040_0033,  1'b1, 5'd0,  5'd4,  32'd4, 32'd1);
    vec("stall5",        1'b0, 1'b1, 1'b0, 32'h0,          32'h0000_0044,  32'h0000_0040,  32'h0040_0033,  1'b1, 5'd0,  5'd4,  32'd5, 32'd1);
    vec("flush_to_top",  1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC,  32'hFFFF_FFFC,  32'h0000_0000,  TB_NOP,         1'b0, 5'd0,  5'd0,  32'd5, 32'd2);
    vec("wrap",          1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_0000,  32'hFFFF_FFFC,  32'hFFFC_0033,  1'b1, 5'd24, 5'd31, 32'd5, 32'd2);
    vec("after_wrap",    1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_0004,  32'h0000_0000,  32'h0000_0033,  1'b1, 5'd0,  5'd0,  32'd5, 32'd2);

    // walk sequentially up to PC = 0x20
    for (int k = 0; k < 7; k++) begin
      a = 32'(4 + 4 * k);
      vec("walk", 1'b1, 1'b0, 1'b0, 32'h0, a + 32'd4, a, {a[15:0], 16'h0033}, 1'b1,
          {a[3:0], 1'b0}, a[8:4], 32'd5, 32'd2);
    end

    // asynchronous reset in mid-cycle, checked before the next rising edge
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    expect_at(cyc_cnt, "async_rst", 32'h0, 32'h0, TB_NOP, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    -> chk_now;
    #1;
    rst = 1'b0;

    vec("post_rst",      1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_0004,  32'h0000_0000,  32'h0000_0033,  1'b1, 5'd0,  5'd0,  32'd0, 32'd0);
    vec("post_rst2",     1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_0008,  32'h0000_0004,  32'h0004_0033,  1'b1, 5'd8,  5'd0,  32'd0, 32'd0);

`ifdef IFID_PERF_EN
    // preload counters next to full scale
    @(negedge clk);
    #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    force dut.flush_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    release dut.flush_cnt_q;
`endif

    vec("sat_stall1",    1'b0, 1'b1, 1'b0, 32'h0,          32'h0000_0008,  32'h0000_0004,  32'h0004_0033,  1'b1, 5'd8,  5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    vec("sat_stall2",    1'b0, 1'b1, 1'b0, 32'h0,          32'h0000_0008,  32'h0000_0004,  32'h0004_0033,  1'b1, 5'd8,  5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    vec("sat_flush",     1'b1, 1'b0, 1'b1, 32'h0000_0100,  32'h0000_0100,  32'h0000_0000,  TB_NOP,         1'b0, 5'd0,  5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    vec("stall_pc_run",  1'b1, 1'b1, 1'b0, 32'h0,          32'h0000_0104,  32'h0000_0000,  TB_NOP,         1'b0, 5'd0,  5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF);

    bus.PCWrite_i = 1'b1;
    bus.Stall_i   = 1'b0;
    bus.Flush_i   = 1'b0;

    tries = 0;
    while (q.size() > 0 && tries < 6) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations never compared, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_if_id_stage
`default_nettype wire
